// File: rtl/bridge_arb_pkg.sv
// ---------------------------------------------------------------------------
// bridge_arb_pkg
//   Shared types for the DRAM bridge arbiter.
//   - arb_state_e : arbiter FSM states
//   - cnt_width() : timeout counter width for a given TIMEOUT
//   The command record (cmd_t) depends on the top's ADDR_W/DATA_W, so the
//   top declares it locally.
// ---------------------------------------------------------------------------
package bridge_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    // Wide enough to hold every value 0..timeout.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. It searches req starting at
//   index ptr and wraps modulo N. The first asserted request wins.
// Ports
//   req     in  N   request vector
//   ptr     in  PW  index with highest priority this cycle
//   gnt_oh  out N   one-hot grant (all zero when no request)
//   gnt_idx out PW  binary index of the grant
//   any     out 1   at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    logic [PW-1:0] w_idx;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_idx   = '0;
        for (int off = 0; off < N; off++) begin
            w_idx = PW'((int'(ptr) + off) % N);
            if (!any && req[w_idx]) begin
                any            = 1'b1;
                gnt_idx        = w_idx;
                gnt_oh[w_idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bridge_arbiter.sv
// ---------------------------------------------------------------------------
// bridge_arbiter
//   Shares one AXI-Lite DRAM bridge between NUM_REQ client engines. One
//   client is granted at a time in round-robin order. Its command is replayed
//   to the bridge as a single-cycle C_in_valid pulse. The arbiter then waits
//   for C_out_valid, or for a timeout, and returns a one-cycle completion to
//   the owning client.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/ready              per-client level request, one-hot accept
//   req_r_wb/addr/data_w         per-client command fields (packed)
//   rsp_valid/data_r/err         one-hot completion, read data, timeout flag
//   C_in_valid/r_wb/addr/data_w  command to the bridge
//   C_out_valid/C_data_r         completion from the bridge
//   busy                         transaction in progress
// ---------------------------------------------------------------------------
module bridge_arbiter
    import bridge_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_r_wb,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_w,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data_r,
    output logic                      rsp_err,
    output logic                      C_in_valid,
    output logic                      C_r_wb,
    output logic [ADDR_W-1:0]         C_addr,
    output logic [DATA_W-1:0]         C_data_w,
    input  logic                      C_out_valid,
    input  logic [DATA_W-1:0]         C_data_r,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = cnt_width(TIMEOUT);

    typedef struct packed {
        logic              r_wb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data_w;
    } cmd_t;

    arb_state_e           r_state;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     r_owner;
    logic [CNT_W-1:0]     r_cnt;
    cmd_t                 r_cmd;
    logic                 r_c_in_valid;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_data;
    logic                 r_rsp_err;

    logic [NUM_REQ-1:0]   w_gnt_oh;
    logic [PTR_W-1:0]     w_gnt_idx;
    logic                 w_any;
    cmd_t                 w_cmd_sel;
    logic [NUM_REQ-1:0]   w_owner_oh;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (r_rr_ptr),
        .gnt_oh  (w_gnt_oh),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // Fields of the client that would be granted this cycle.
    always_comb begin
        w_cmd_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_oh[i]) begin
                w_cmd_sel.r_wb   = req_r_wb[i];
                w_cmd_sel.addr   = req_addr[i*ADDR_W +: ADDR_W];
                w_cmd_sel.data_w = req_data_w[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_owner_oh = NUM_REQ'(1) << r_owner;

    // Accept only in IDLE. Masking with rst keeps every output low while the
    // reset is asserted.
    assign req_ready  = (r_state == IDLE && !rst) ? w_gnt_oh : '0;

    assign C_in_valid = r_c_in_valid;
    assign C_r_wb     = r_cmd.r_wb;
    assign C_addr     = r_cmd.addr;
    assign C_data_w   = r_cmd.data_w;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data_r = r_rsp_data;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_cnt        <= '0;
            r_cmd        <= '0;
            r_c_in_valid <= 1'b0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            // Pulse outputs default low; each state raises them for one cycle only.
            r_c_in_valid <= 1'b0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner      <= w_gnt_idx;
                        r_cmd        <= w_cmd_sel;
                        r_c_in_valid <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A bridge completion takes precedence over a timeout that expires in the same cycle.
                    if (C_out_valid) begin
                        r_rsp_valid <= w_owner_oh;
                        r_rsp_data  <= r_cmd.r_wb ? C_data_r : '0;
                        r_state     <= RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_rsp_valid <= w_owner_oh;
                        r_rsp_err   <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_rr_ptr <= (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
                    r_cnt    <= '0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bridge_arbiter.sv
module tb_bridge_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 64;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      req_valid, req_ready, req_r_wb, rsp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data_w;
    logic [DW-1:0]     rsp_data_r, C_data_w, C_data_r;
    logic              rsp_err, C_in_valid, C_r_wb, C_out_valid, busy;
    logic [AW-1:0]     C_addr;

    bridge_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_r_wb(req_r_wb),
        .req_addr(req_addr), .req_data_w(req_data_w),
        .rsp_valid(rsp_valid), .rsp_data_r(rsp_data_r), .rsp_err(rsp_err),
        .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
        .C_out_valid(C_out_valid), .C_data_r(C_data_r), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Client stimulus state
    bit            cl_pend [N];
    bit            cl_rwb  [N];
    logic [AW-1:0] cl_addr [N];
    logic [DW-1:0] cl_data [N];
    bit            refill, rand_new;
    int            new_pct, drop_pct;

    // Bridge stimulus state
    int            br_due, br_lat_min, br_lat_max, stray_permille;
    bit            br_silent, br_fix_en, stray_force;
    logic [DW-1:0] br_fix_data, br_data;

    // Reference model: one transaction described by its cycle timestamps
    bit            m_active;
    int            m_ptr, m_owner, m_issue, m_resp, m_deadline;
    bit            m_rwb, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_dataw, m_rdata;

    // Observation log
    int            grant_log[$];
    int            cin_cnt, last_cin_cyc, last_rsp_cyc, rsp_seen;
    logic [AW-1:0] last_cin_addr;
    logic [DW-1:0] last_cin_data, last_rsp_data;
    bit            last_cin_rwb, last_rsp_err;
    logic [N-1:0]  last_rsp_valid;

    task automatic step();
        int g;
        logic [N-1:0]  e_ready, e_rsp;
        logic [DW-1:0] e_data;
        bit            e_err, e_cin;
        // drive inputs for this cycle
        for (int i = 0; i < N; i++) begin
            if (!cl_pend[i] && (refill || (rand_new && $urandom_range(99) < new_pct))) begin
                cl_pend[i] = 1'b1;
                if (rand_new) begin
                    cl_rwb[i]  = $urandom_range(1);
                    cl_addr[i] = AW'($urandom);
                    cl_data[i] = {$urandom, $urandom};
                end
            end else if (rand_new && cl_pend[i] && $urandom_range(99) < drop_pct) begin
                cl_pend[i] = 1'b0;
            end
            req_valid[i]             = cl_pend[i];
            req_r_wb[i]              = cl_rwb[i];
            req_addr[i*AW +: AW]     = cl_addr[i];
            req_data_w[i*DW +: DW]   = cl_data[i];
        end
        C_out_valid = (cyc == br_due) || stray_force || ($urandom_range(999) < stray_permille);
        C_data_r    = (cyc == br_due) ? br_data : {$urandom, $urandom};
        #1;
        // expected outputs from the model
        g = -1;
        if (!rst && !m_active)
            for (int off = 0; off < N; off++)
                if (g < 0 && req_valid[(m_ptr + off) % N]) g = (m_ptr + off) % N;
        e_ready = (g >= 0) ? N'(1) << g : '0;
        e_cin   = m_active && (cyc == m_issue);
        e_rsp   = (m_active && cyc == m_resp) ? N'(1) << m_owner : '0;
        e_data  = (m_active && cyc == m_resp) ? m_rdata : '0;
        e_err   = (m_active && cyc == m_resp) ? m_err : 1'b0;
        chk("req_ready",  req_ready,  e_ready);
        chk("C_in_valid", C_in_valid, e_cin);
        chk("C_r_wb",     C_r_wb,     m_rwb);
        chk("C_addr",     C_addr,     m_addr);
        chk("C_data_w",   C_data_w,   m_dataw);
        chk("rsp_valid",  rsp_valid,  e_rsp);
        chk("rsp_data_r", rsp_data_r, e_data);
        chk("rsp_err",    rsp_err,    e_err);
        chk("busy",       busy,       m_active);
        // observations
        for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
        if (C_in_valid) begin
            cin_cnt++;
            last_cin_cyc  = cyc;
            last_cin_addr = C_addr;
            last_cin_rwb  = C_r_wb;
            last_cin_data = C_data_w;
        end
        if (rsp_valid != '0) begin
            rsp_seen++;
            last_rsp_cyc   = cyc;
            last_rsp_valid = rsp_valid;
            last_rsp_data  = rsp_data_r;
            last_rsp_err   = rsp_err;
        end
        for (int i = 0; i < N; i++) if (req_ready[i]) cl_pend[i] = 1'b0;
        if (e_cin && !br_silent) begin
            br_due  = cyc + $urandom_range(br_lat_max, br_lat_min);
            br_data = br_fix_en ? br_fix_data : {$urandom, $urandom};
        end
        // advance the model
        if (rst) begin
            m_active = 1'b0; m_ptr = 0; m_rwb = 1'b0; m_addr = '0; m_dataw = '0;
            br_due = -1;
        end else if (g >= 0) begin
            m_active   = 1'b1;
            m_owner    = g;
            m_rwb      = req_r_wb[g];
            m_addr     = req_addr[g*AW +: AW];
            m_dataw    = req_data_w[g*DW +: DW];
            m_issue    = cyc + 1;
            m_resp     = -1;
            m_deadline = cyc + 1 + TO;
        end else if (m_active && m_resp < 0 && cyc > m_issue) begin
            if (C_out_valid) begin
                m_resp = cyc + 1; m_rdata = m_rwb ? C_data_r : '0; m_err = 1'b0;
            end else if (cyc == m_deadline) begin
                m_resp = cyc + 1; m_rdata = '0; m_err = 1'b1;
            end
        end else if (m_active && cyc == m_resp) begin
            m_ptr    = (m_owner + 1) % N;
            m_active = 1'b0;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_log();
        grant_log.delete();
        cin_cnt = 0; rsp_seen = 0; last_cin_cyc = -1; last_rsp_cyc = -1;
    endtask

    task automatic run_to_rsp(input int limit);
        for (int k = 0; k < limit && last_rsp_cyc < 0; k++) step();
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            cl_pend[i] = 1'b0; cl_rwb[i] = 1'b0; cl_addr[i] = '0; cl_data[i] = '0;
        end
        refill = 0; rand_new = 0; new_pct = 0; drop_pct = 0;
        br_due = -1; br_lat_min = 1; br_lat_max = 1; stray_permille = 0;
        br_silent = 0; br_fix_en = 0; stray_force = 0; br_fix_data = '0; br_data = '0;
        req_valid = '0; req_r_wb = '0; req_addr = '0; req_data_w = '0;
        C_out_valid = 1'b0; C_data_r = '0;
        m_active = 0; m_ptr = 0; m_owner = 0; m_issue = -1; m_resp = -1; m_deadline = -1;
        m_rwb = 0; m_err = 0; m_addr = '0; m_dataw = '0; m_rdata = '0;
        clear_log();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step();

        // single read from client 2, bridge answers 4 cycles after the pulse
        clear_log();
        cl_pend[2] = 1; cl_rwb[2] = 1; cl_addr[2] = 8'h05; cl_data[2] = 64'h55;
        br_lat_min = 4; br_lat_max = 4; br_fix_en = 1; br_fix_data = 64'hDEAD_BEEF;
        run_to_rsp(40);
        chk("t1_done", last_rsp_cyc >= 0, 1);
        chk("t1_addr", last_cin_addr, 8'h05);
        chk("t1_pulses", cin_cnt, 1);
        chk("t1_lat", last_rsp_cyc - last_cin_cyc, 5);
        chk("t1_rsp_valid", last_rsp_valid, 4'b0100);
        chk("t1_data", last_rsp_data, 64'hDEAD_BEEF);
        chk("t1_err", last_rsp_err, 0);
        repeat (2) step();

        // write from client 0; bridge returns nonzero data that must be dropped
        clear_log();
        cl_pend[0] = 1; cl_rwb[0] = 0; cl_addr[0] = 8'hFF; cl_data[0] = 64'h1234;
        br_lat_min = 2; br_lat_max = 2; br_fix_data = 64'hFFFF_0000_AAAA_5555;
        run_to_rsp(40);
        chk("t2_done", last_rsp_cyc >= 0, 1);
        chk("t2_rwb", last_cin_rwb, 0);
        chk("t2_wdata", last_cin_data, 64'h1234);
        chk("t2_rsp_valid", last_rsp_valid, 4'b0001);
        chk("t2_data", last_rsp_data, 0);
        repeat (2) step();

        // contention from reset: all four clients keep requesting
        rst = 1; step(); rst = 0;
        clear_log();
        br_fix_en = 0;
        refill = 1;
        for (int k = 0; k < 100 && grant_log.size() < 5; k++) step();
        refill = 0;
        for (int i = 0; i < N; i++) cl_pend[i] = 0;
        repeat (20) step();
        chk("t3_ngrants", grant_log.size() >= 5, 1);
        if (grant_log.size() >= 5)
            for (int i = 0; i < 5; i++) chk($sformatf("t3_grant%0d", i), grant_log[i], i % N);
        chk("t3_pulses", cin_cnt, grant_log.size());

        // timeout with a silent bridge
        clear_log();
        br_silent = 1;
        cl_pend[1] = 1; cl_rwb[1] = 1; cl_addr[1] = 8'h3C;
        run_to_rsp(60);
        chk("t4_done", last_rsp_cyc >= 0, 1);
        chk("t4_lat", last_rsp_cyc - (last_cin_cyc + 1), TO);
        chk("t4_err", last_rsp_err, 1);
        chk("t4_data", last_rsp_data, 0);
        repeat (2) step();
        // completion on the last WAIT cycle beats the timeout
        clear_log();
        br_silent = 0; br_lat_min = TO; br_lat_max = TO; br_fix_en = 1; br_fix_data = 64'hC0FFEE;
        cl_pend[1] = 1;
        run_to_rsp(60);
        chk("t4b_done", last_rsp_cyc >= 0, 1);
        chk("t4b_lat", last_rsp_cyc - last_cin_cyc, TO + 1);
        chk("t4b_err", last_rsp_err, 0);
        chk("t4b_data", last_rsp_data, 64'hC0FFEE);
        repeat (2) step();

        // reset while waiting on the bridge
        clear_log();
        br_silent = 1;
        cl_pend[3] = 1; cl_rwb[3] = 1; cl_addr[3] = 8'h77;
        for (int k = 0; k < 20 && last_cin_cyc < 0; k++) step();
        repeat (3) step();
        chk("t5_busy_before", busy, 1);
        rst = 1; step(); rst = 0;
        chk("t5_busy", busy, 0);
        chk("t5_cin", C_in_valid, 0);
        chk("t5_addr", C_addr, 0);
        chk("t5_rsp", rsp_valid, 0);
        repeat (20) step();
        chk("t5_no_rsp", rsp_seen, 0);
        clear_log();
        br_silent = 0; br_lat_min = 1; br_lat_max = 3; br_fix_en = 0;
        refill = 1;
        for (int k = 0; k < 10 && grant_log.size() < 1; k++) step();
        refill = 0;
        for (int i = 0; i < N; i++) cl_pend[i] = 0;
        chk("t5_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        repeat (10) step();

        // stray bridge completion while idle
        clear_log();
        stray_force = 1; step(); stray_force = 0;
        repeat (3) step();
        chk("t6_no_rsp", rsp_seen, 0);
        chk("t6_busy", busy, 0);

        // randomized traffic, late/lost responses, strays and occasional resets
        rand_new = 1; new_pct = 30; drop_pct = 3;
        br_lat_min = 1; br_lat_max = 20; stray_permille = 10;
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(299) == 0);
            step();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
